sine_source: RTL and testbench

- Multichannel test-tone source: the transmitting end of the interleaved sample interface (sample data, channel, data-valid, ready) that the limiter consumes.
- Per channel: DDS phase accumulator plus a quarter-wave sine ROM, round-robin channel interleave, amplitude shift and mute.
- Used as synthesizable stimulus in-FPGA and on benches in place of a behavioural generator.

---
 rtl/sine_source_pkg.sv | 42 ++++
 rtl/sine_quarter_rom.sv | 27 ++
 rtl/sine_source.sv | 121 ++++++++++++
 tb/tb_sine_source.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_source_pkg.sv
// Shared types and constants for the multichannel DDS test-tone source:
// FSM state encoding, quadrant type, quarter-wave ROM generator and LFSR constants.
package sine_source_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  typedef logic [1:0] quadrant_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  localparam real PI = 3.14159265358979323846;

  // Entry idx of the quarter-wave table, sampled at half-step offsets so the
  // mirrored and negated quadrants reuse the same codes exactly.
  function automatic longint rom_entry(input int ow, input int lut_aw, input int idx);
    real span;
    real amp;
    real x;
    real term;
    real acc;
    span = 1.0;
    for (int i = 0; i < lut_aw + 1; i++) span = span * 2.0;
    amp = 1.0;
    for (int i = 0; i < ow - 1; i++) amp = amp * 2.0;
    amp  = amp - 1.0;
    x    = (real'(idx) + 0.5) * PI / span;
    term = x;
    acc  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return longint'($rtoi(amp * acc + 0.5));
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a one-cycle registered read; contents are
// built at elaboration from sine_source_pkg::rom_entry.
module sine_quarter_rom
  import sine_source_pkg::*;
#(
  parameter int OW     = 30,
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [OW-2:0]     data
);

  logic [OW-2:0] rom_table [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_entry
    localparam longint ENTRY = rom_entry(OW, LUT_AW, i);
    assign rom_table[i] = ENTRY[OW-2:0];
  end

  // NOTE: the table and its read register carry no reset; they hold constants and
  // are only consumed once the FSM has issued a lookup.
  always_ff @(posedge clk) begin
    data <= rom_table[addr];
  end

endmodule

// File: rtl/sine_source.sv
// Multichannel DDS tone source driving the interleaved sg_d/sg_ch/sg_dv/sg_dr interface.
// Optional dither: define SINE_SOURCE_DITHER_EN to add a +/-1 LSB LFSR dither before the shift.
module sine_source
  import sine_source_pkg::*;
#(
  parameter int NR_CHANNELS  = 3,
  parameter int OUTPUT_WIDTH = 30,
  parameter int PHASE_WIDTH  = 32,
  parameter int LUT_AW       = 8,
  parameter int CHW          = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [NR_CHANNELS*PHASE_WIDTH-1:0]  phase_inc,
  input  logic [3:0]                          amp_shift,
  input  logic                                mute,
  output logic signed [OUTPUT_WIDTH-1:0]      sg_d,
  output logic [CHW-1:0]                      sg_ch,
  output logic                                sg_dv,
  input  logic                                sg_dr
);

  localparam int OW = OUTPUT_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NR_CHANNELS - 1);

  state_t             state;
  logic [PW-1:0]      phase [NR_CHANNELS];
  logic [CHW-1:0]     ch;
  logic [PW-1:0]      inc_q;
  quadrant_t          quad_q;
  logic [LUT_AW-1:0]  addr;
  logic [OW-2:0]      rom_data;
  logic signed [OW:0] mag;
  logic signed [OW:0] signed_val;
  logic signed [OW:0] limited;
  logic signed [OW-1:0] base;
  logic signed [OW-1:0] shaped;

  // Odd quadrants walk the quarter table backwards.
  assign addr = phase[ch][PW-2] ? ~phase[ch][PW-3 -: LUT_AW] : phase[ch][PW-3 -: LUT_AW];

  sine_quarter_rom #(
    .OW     (OW),
    .LUT_AW (LUT_AW)
  ) u_rom (
    .clk  (clk),
    .addr (addr),
    .data (rom_data)
  );

`ifdef SINE_SOURCE_DITHER_EN
  localparam logic signed [OW:0] PEAK = {2'b00, {(OW-1){1'b1}}};
  logic [15:0]        lfsr;
  logic signed [OW:0] dsum;

  // Seeded only by rst_n so that enable toggling keeps the dither sequence running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (enable && state == EMIT) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    mag        = {2'b00, rom_data};
    signed_val = quad_q[1] ? -mag : mag;
`ifdef SINE_SOURCE_DITHER_EN
    dsum = signed_val + $signed({{OW{1'b0}}, lfsr[0]}) - $signed({{OW{1'b0}}, lfsr[1]});
    if (dsum > PEAK)       limited = PEAK;
    else if (dsum < -PEAK) limited = -PEAK;
    else                   limited = dsum;
`else
    limited = signed_val;
`endif
    base   = limited[OW-1:0];
    shaped = base >>> amp_shift;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state  <= IDLE;
      ch     <= '0;
      inc_q  <= '0;
      quad_q <= '0;
      sg_d   <= '0;
      sg_ch  <= '0;
      sg_dv  <= 1'b0;
      for (int c = 0; c < NR_CHANNELS; c++) phase[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sg_dr) begin
            quad_q <= phase[ch][PW-1 -: 2];
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          inc_q <= phase_inc[int'(ch)*PW +: PW];
          sg_d  <= mute ? '0 : shaped;
          sg_ch <= ch;
          sg_dv <= 1'b1;
          state <= EMIT;
        end
        EMIT: begin
          sg_dv     <= 1'b0;
          phase[ch] <= phase[ch] + inc_q;
          ch        <= (ch == LAST_CH) ? '0 : ch + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_source.sv
// Directed self-checking bench for sine_source (3 channels, 30-bit samples, 8-bit quarter ROM).
module tb_sine_source;

  localparam int N  = 3;
  localparam int OW = 30;
  localparam int PW = 32;
  localparam int AW = 8;
`ifdef SINE_SOURCE_DITHER_EN
  localparam longint TOL = 1;
`else
  localparam longint TOL = 0;
`endif
  localparam longint PEAK = (longint'(1) << (OW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic [N*PW-1:0]      phase_inc = '0;
  logic [3:0]           amp_shift = 4'd0;
  logic                 mute = 1'b0;
  logic signed [OW-1:0] sg_d;
  logic [1:0]           sg_ch;
  logic                 sg_dv;
  logic                 sg_dr = 1'b0;

  int checks = 0;
  int errors = 0;

  longint        rom_ref [2**AW];
  logic [PW-1:0] m_phase [N];
  int            m_ch;

  always #5 clk = ~clk;

  sine_source #(
    .NR_CHANNELS  (N),
    .OUTPUT_WIDTH (OW),
    .PHASE_WIDTH  (PW),
    .LUT_AW       (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .phase_inc (phase_inc),
    .amp_shift (amp_shift),
    .mute      (mute),
    .sg_d      (sg_d),
    .sg_ch     (sg_ch),
    .sg_dv     (sg_dv),
    .sg_dr     (sg_dr)
  );

  function automatic longint ref_value(input logic [PW-1:0] ph);
    logic [1:0]    q;
    logic [AW-1:0] a;
    longint        v;
    q = ph[PW-1 -: 2];
    a = ph[PW-3 -: AW];
    if (q[0]) a = ~a;
    v = rom_ref[a];
    if (q[1]) v = -v;
    return v;
  endfunction

  function automatic bit close(input longint got, input longint exp);
    return (got - exp <= TOL) && (exp - got <= TOL);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_phase[c] = '0;
    m_ch = 0;
  endtask

  task automatic model_step(output longint exp_d, output int exp_ch);
    longint raw;
    exp_ch = m_ch;
    raw    = ref_value(m_phase[m_ch]);
    exp_d  = mute ? 64'sd0 : (raw >>> amp_shift);
    m_phase[m_ch] = m_phase[m_ch] + phase_inc[m_ch*PW +: PW];
    m_ch = (m_ch + 1) % N;
  endtask

  // Waits for the next strobe within a bounded window, then advances the model.
  task automatic capture(output longint d, output int ch, output int waited,
                         output longint exp_d, output int exp_ch);
    bit ok;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      waited++;
      if (sg_dv === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL strobe_timeout: no sg_dv within %0d cycles, required one", waited);
    end
    d  = longint'(sg_d);
    ch = int'(sg_ch);
    model_step(exp_d, exp_ch);
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    tick();
    model_reset();
    enable = 1'b1;
    sg_dr  = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    enable = 1'b0;
    sg_dr = 1'b1;
    repeat (4) tick();
    checks++;
    if (sg_dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b, expected 0", sg_dv); end
    checks++;
    if (sg_d !== '0) begin errors++; $display("FAIL reset_d: got %0d, expected 0", sg_d); end
    checks++;
    if (sg_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d, expected 0", sg_ch); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sg_dv !== 1'b0 || sg_d !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL enable_low_hold: %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_enable_latency();
    longint d, exp_d;
    int     ch, exp_ch;
    phase_inc = '0;
    phase_inc[0*PW +: PW] = 32'h4000_0000;
    model_reset();
    enable = 1'b1;
    tick();
    checks++;
    if (sg_dv !== 1'b0) begin errors++; $display("FAIL latency_lookup_dv: got %b, expected 0", sg_dv); end
    tick();
    checks++;
    if (sg_dv !== 1'b1) begin errors++; $display("FAIL latency_emit_dv: got %b, expected 1", sg_dv); end
    checks++;
    if (sg_ch !== 2'd0) begin errors++; $display("FAIL first_ch: got %0d, expected 0", sg_ch); end
    d = longint'(sg_d);
    checks++;
    if (!close(d, rom_ref[0])) begin errors++; $display("FAIL first_d: got %0d, expected %0d", d, rom_ref[0]); end
    model_step(exp_d, exp_ch);
  endtask

  task automatic test_interleave();
    longint d, exp_d;
    int     ch, exp_ch, waited, bad;
    for (int k = 0; k < 8; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (waited != 3) begin errors++; $display("FAIL interleave_spacing[%0d]: got %0d, expected 3", k, waited); end
      checks++;
      if (ch != exp_ch) begin errors++; $display("FAIL interleave_ch[%0d]: got %0d, expected %0d", k, ch, exp_ch); end
      checks++;
      if (!close(d, exp_d)) begin errors++; $display("FAIL interleave_d[%0d]: got %0d, expected %0d", k, d, exp_d); end
    end
    sg_dr = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sg_dv !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dr_low_idle: %0d strobes, expected 0", bad); end
    sg_dr = 1'b1;
    tick();
    sg_dr = 1'b0;
    tick();
    checks++;
    if (sg_dv !== 1'b1) begin errors++; $display("FAIL dr_drop_inflight: got %b, expected 1", sg_dv); end
    d = longint'(sg_d);
    ch = int'(sg_ch);
    model_step(exp_d, exp_ch);
    checks++;
    if (ch != exp_ch || !close(d, exp_d)) begin
      errors++;
      $display("FAIL dr_drop_sample: got ch %0d d %0d, expected ch %0d d %0d", ch, d, exp_ch, exp_d);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sg_dv !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dr_drop_after: %0d strobes, expected 0", bad); end
  endtask

  task automatic test_symmetry();
    longint d, exp_d, seq [4], hi, lo;
    int     ch, exp_ch, waited, k0;
    seq[0] = rom_ref[0];
    seq[1] = rom_ref[255];
    seq[2] = -rom_ref[0];
    seq[3] = -rom_ref[255];
    phase_inc = '0;
    phase_inc[0*PW +: PW] = 32'h4000_0000;
    amp_shift = 4'd0;
    mute = 1'b0;
    restart();
    k0 = 0;
    hi = -PEAK;
    lo = PEAK;
    for (int k = 0; k < 24; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      if (d > hi) hi = d;
      if (d < lo) lo = d;
      if (ch == 0) begin
        checks++;
        if (!close(d, seq[k0 % 4])) begin
          errors++;
          $display("FAIL symmetry_ch0[%0d]: got %0d, expected %0d", k0, d, seq[k0 % 4]);
        end
        k0++;
      end else begin
        checks++;
        if (!close(d, rom_ref[0])) begin
          errors++;
          $display("FAIL zero_inc_ch%0d: got %0d, expected %0d", ch, d, rom_ref[0]);
        end
      end
    end
    checks++;
    if (!close(hi, rom_ref[255]) || hi > PEAK) begin
      errors++; $display("FAIL symmetry_peak: got %0d, expected %0d", hi, rom_ref[255]);
    end
    checks++;
    if (!close(lo, -rom_ref[255]) || lo < -PEAK) begin
      errors++; $display("FAIL symmetry_trough: got %0d, expected %0d", lo, -rom_ref[255]);
    end
  endtask

  task automatic test_frequency();
    longint d, exp_d, prev;
    int     ch, exp_ch, waited, n0, crossings, bad;
    phase_inc = '0;
    phase_inc[0*PW +: PW] = 32'd90373270;
    phase_inc[1*PW +: PW] = 32'd12345678;
    phase_inc[2*PW +: PW] = 32'h8000_0000;
    restart();
    n0 = 0;
    crossings = 0;
    bad = 0;
    prev = 0;
    while (n0 < 3000) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (ch != exp_ch || !close(d, exp_d)) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL freq_sample: got ch %0d d %0d, expected ch %0d d %0d", ch, d, exp_ch, exp_d);
      end
      if (ch == 0) begin
        if (n0 > 0 && prev < 0 && d > 0) crossings++;
        prev = d;
        n0++;
      end
    end
    checks++;
    if (crossings < 62 || crossings > 64) begin
      errors++; $display("FAIL freq_crossings: got %0d, expected 63 +/- 1", crossings);
    end
  endtask

  task automatic test_shift_mute();
    longint d, exp_d;
    int     ch, exp_ch, waited;
    phase_inc = '0;
    phase_inc[0*PW +: PW] = 32'd90373270;
    phase_inc[1*PW +: PW] = 32'h4000_0000;
    phase_inc[2*PW +: PW] = 32'h0700_0000;
    amp_shift = 4'd7;
    mute = 1'b0;
    restart();
    for (int k = 0; k < 9; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (ch != exp_ch || !close(d, exp_d)) begin
        errors++; $display("FAIL shift7[%0d]: got ch %0d d %0d, expected ch %0d d %0d", k, ch, d, exp_ch, exp_d);
      end
    end
    mute = 1'b1;
    for (int k = 0; k < 20; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (d != 0 || waited != 3) begin
        errors++; $display("FAIL mute[%0d]: got d %0d spacing %0d, expected d 0 spacing 3", k, d, waited);
      end
    end
    mute = 1'b0;
    for (int k = 0; k < 6; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (ch != exp_ch || !close(d, exp_d)) begin
        errors++; $display("FAIL unmute[%0d]: got ch %0d d %0d, expected ch %0d d %0d", k, ch, d, exp_ch, exp_d);
      end
    end
    amp_shift = 4'd15;
    for (int k = 0; k < 3; k++) begin
      capture(d, ch, waited, exp_d, exp_ch);
      checks++;
      if (ch != exp_ch || !close(d, exp_d)) begin
        errors++; $display("FAIL shift15[%0d]: got ch %0d d %0d, expected ch %0d d %0d", k, ch, d, exp_ch, exp_d);
      end
    end
  endtask

  initial begin
    real amp;
    amp = 536870911.0;
    for (int i = 0; i < 2**AW; i++)
      rom_ref[i] = longint'($rtoi(amp * $sin((real'(i) + 0.5) * 3.14159265358979323846 / 512.0) + 0.5));
    model_reset();
    test_reset();
    test_enable_latency();
    test_interleave();
    test_symmetry();
    test_frequency();
    test_shift_mute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
